mem_lane_port: RTL and testbench

Single-port, byte-lane-addressable synchronous block RAM with a valid/ready request channel and a valid/ready response channel. It replaces the plain word RAM behind the RV32I load/store unit. It also performs sub-word writes (SB/SH/SW) and load alignment with sign/zero extension (LB/LBU/LH/LHU/LW), and it flags misaligned accesses instead of corrupting memory. It is parametrised in depth and data width, and it can optionally add an output register stage for timing closure.

---
 rtl/mem_lane_pkg.sv | 40 ++++
 rtl/mem_load_align.sv | 39 +++
 rtl/mem_lane_port.sv | 167 ++++++++++++++++
 tb/tb_mem_lane_port.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lane_pkg.sv
// Shared types and helpers for the byte-lane memory port.
package mem_lane_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'd0,
        MEM_HALF  = 2'd1,
        MEM_WORD  = 2'd2,
        MEM_DWORD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PIPE = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    // Byte enables for an access of the given size starting at the given lane.
    // Sized for the widest word (8 lanes); callers truncate to their lane count.
    function automatic logic [7:0] lane_mask(input mem_size_t size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            MEM_BYTE: base = 8'h01;
            MEM_HALF: base = 8'h03;
            MEM_WORD: base = 8'h0F;
            default:  base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    // An access is misaligned when its lane offset is not a multiple of its size.
    function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] offset);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return offset[0];
            MEM_WORD: return |offset[1:0];
            default:  return |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: shifts the addressed lanes down to bit 0 and sign- or
// zero-extends them to the full word width.
module mem_load_align
    import mem_lane_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0]     word_i,
    input  logic [$clog2(LANES)-1:0]  offset_i,
    input  mem_size_t                 size_i,
    input  logic                      unsigned_i,
    output logic [DATA_WIDTH-1:0]     data_o
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  signBit;
    logic                  fill;
    int                    keep;

    // Select the addressed lanes and fill the upper bits with the extension bit.
    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        keep    = DATA_WIDTH;
        signBit = shifted[DATA_WIDTH-1];
        data_o  = '0;
        case (size_i)
            MEM_BYTE: begin keep = 8;  signBit = shifted[7];  end
            MEM_HALF: begin keep = 16; signBit = shifted[15]; end
            MEM_WORD: begin keep = 32; signBit = shifted[31]; end
            default:  begin keep = DATA_WIDTH; signBit = shifted[DATA_WIDTH-1]; end
        endcase
        fill = signBit & ~unsigned_i;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data_o[i] = (i < keep) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/mem_lane_port.sv
// Byte-lane addressable single-port RAM with valid/ready request and response
// channels, sub-word stores, aligned/extended loads and misalignment flagging.
// Optional feature: define MEM_OUTPUT_REG_EN to add an output register stage
// (extra PIPE state, latency 2, one request per 2 cycles).
module mem_lane_port
    import mem_lane_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = DATA_WIDTH / 8,
    parameter     INIT_FILE  = ""
) (
    input  logic                                 clk_i,
    input  logic                                 reset_ni,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic                                 req_we_i,
    input  logic [ADDR_WIDTH+$clog2(LANES)-1:0]  req_addr_i,
    input  logic [1:0]                           req_size_i,
    input  logic                                 req_unsigned_i,
    input  logic [DATA_WIDTH-1:0]                req_wdata_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [DATA_WIDTH-1:0]                rsp_rdata_o,
    output logic                                 rsp_err_o
);

    localparam int OFF_W = $clog2(LANES);
    localparam int BA_W  = ADDR_WIDTH + OFF_W;

    localparam mem_state_t ACCEPT_ST =
`ifdef MEM_OUTPUT_REG_EN
        ST_PIPE;
`else
        ST_RESP;
`endif

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    mem_state_t            state_q, state_d;
    mem_size_t             size_q;
    logic [OFF_W-1:0]      offset_q;
    logic                  unsigned_q;
    logic                  loadOk_q;
    logic                  err_q;

    mem_size_t             reqSize;
    logic [OFF_W-1:0]      reqOff;
    logic [ADDR_WIDTH-1:0] reqWord;
    logic                  reqErr;
    logic                  accept;
    logic [LANES-1:0]      byteEn;
    logic [DATA_WIDTH-1:0] wdataRep;
    logic [DATA_WIDTH-1:0] alignedData;
    logic [DATA_WIDTH-1:0] respData;

    assign reqSize = mem_size_t'(req_size_i);
    assign reqOff  = req_addr_i[OFF_W-1:0];
    assign reqWord = req_addr_i[BA_W-1:OFF_W];
    assign reqErr  = is_misaligned(reqSize, 3'(reqOff)) || (reqSize == MEM_DWORD && DATA_WIDTH < 64);
    assign byteEn  = LANES'(lane_mask(reqSize, 3'(reqOff)));

    // Nothing is accepted while reset is held, so stray requests cannot write.
    assign req_ready_o = (state_q == ST_IDLE) || (state_q == ST_RESP && rsp_ready_i);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign accept      = req_valid_i && req_ready_o && reset_ni;

    // Replicate the right-justified store data across every lane of the word.
    always_comb begin
        wdataRep = req_wdata_i;
        case (reqSize)
            MEM_BYTE: wdataRep = {(DATA_WIDTH/8){req_wdata_i[7:0]}};
            MEM_HALF: wdataRep = {(DATA_WIDTH/16){req_wdata_i[15:0]}};
            MEM_WORD: wdataRep = {(DATA_WIDTH/32){req_wdata_i[31:0]}};
            default:  wdataRep = req_wdata_i;
        endcase
    end

    // Array access at the accept edge: lane-masked write or full-word read; never reset.
    always_ff @(posedge clk_i) begin
        if (accept && !reqErr) begin
            if (req_we_i) begin
                for (int i = 0; i < LANES; i++) begin
                    if (byteEn[i]) begin
                        mem_q[reqWord][i*8 +: 8] <= wdataRep[i*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[reqWord];
            end
        end
    end

    // Capture the request attributes needed to shape the response.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            size_q     <= MEM_BYTE;
            offset_q   <= '0;
            unsigned_q <= 1'b0;
            loadOk_q   <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept) begin
            size_q     <= reqSize;
            offset_q   <= reqOff;
            unsigned_q <= req_unsigned_i;
            loadOk_q   <= !req_we_i && !reqErr;
            err_q      <= reqErr;
        end
    end

    mem_load_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES)
    ) u_align (
        .word_i     (rdata_q),
        .offset_i   (offset_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (alignedData)
    );

    assign respData = loadOk_q ? alignedData : '0;

`ifdef MEM_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] outData_q;
    logic                  outErr_q;

    // Output register stage, loaded while the FSM passes through PIPE.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            outData_q <= '0;
            outErr_q  <= 1'b0;
        end else if (state_q == ST_PIPE) begin
            outData_q <= respData;
            outErr_q  <= err_q;
        end
    end

    assign rsp_rdata_o = outData_q;
    assign rsp_err_o   = outErr_q;
`else
    assign rsp_rdata_o = respData;
    assign rsp_err_o   = err_q;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a response is held until the consumer takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ACCEPT_ST;
            ST_PIPE: state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i) state_d = accept ? ACCEPT_ST : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_lane_port.sv
// Self-checking bench for mem_lane_port (default 32-bit build; honours
// MEM_OUTPUT_REG_EN for the expected latency and throughput).
module tb_mem_lane_port;

`ifdef MEM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [14:0] reqAddr;
    logic [1:0]  reqSize;
    logic        reqUns;
    logic [31:0] reqWdata;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;

    int checks = 0;
    int passed = 0;

    // Reference memory: a flat byte array covering the addresses the bench uses.
    logic [7:0] mdl [64];

    mem_lane_port dut (
        .clk_i          (clk),
        .reset_ni       (resetN),
        .req_valid_i    (reqValid),
        .req_ready_o    (reqReady),
        .req_we_i       (reqWe),
        .req_addr_i     (reqAddr),
        .req_size_i     (reqSize),
        .req_unsigned_i (reqUns),
        .req_wdata_i    (reqWdata),
        .rsp_valid_o    (rspValid),
        .rsp_ready_i    (rspReady),
        .rsp_rdata_o    (rspRdata),
        .rsp_err_o      (rspErr)
    );

    always #5 clk = ~clk;

    function automatic logic expErr(input int addr, input int size);
        return (size == 3) || ((addr % (1 << size)) != 0);
    endfunction

    function automatic logic [31:0] expLoad(input int addr, input int size, input logic uns);
        logic [63:0] v;
        int n;
        n = 1 << size;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mdl[addr+k];
        if (!uns && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
        return v[31:0];
    endfunction

    task automatic modelStore(input int addr, input int size, input logic [31:0] wdata);
        for (int k = 0; k < (1 << size); k++) mdl[addr+k] = wdata[8*k +: 8];
    endtask

    // One complete transaction with the consumer always ready; lat = -1 on timeout.
    task automatic doReq(input logic we, input int addr, input int size, input logic uns,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
        int waitCnt;
        @(negedge clk);
        reqValid = 1'b1; reqWe = we; reqAddr = 15'(addr); reqSize = 2'(size);
        reqUns = uns; reqWdata = wdata; rspReady = 1'b1;
        #1;
        waitCnt = 0;
        while (!reqReady && waitCnt < 20) begin
            @(negedge clk); waitCnt++;
        end
        rdata = '0; err = 1'b0;
        if (!reqReady) begin
            reqValid = 1'b0; lat = -1;
            return;
        end
        @(posedge clk);
        #1 reqValid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!rspValid && lat < 20);
        if (!rspValid) lat = -1;
        rdata = rspRdata;
        err   = rspErr;
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reqValid = 1'($urandom); reqWe = 1'($urandom); reqAddr = 15'($urandom);
            reqSize = 2'($urandom); reqUns = 1'($urandom); reqWdata = $urandom;
            rspReady = 1'($urandom);
        end
        #1;
        checks++; if (reqReady !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", reqReady); else passed++;
        checks++; if (rspValid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", rspValid); else passed++;
        checks++; if (rspRdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h want 0", rspRdata); else passed++;
        checks++; if (rspErr !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", rspErr); else passed++;
        @(negedge clk);
        reqValid = 1'b0; rspReady = 1'b1;
        resetN = 1'b1;
    endtask

    task automatic preload;
        logic [31:0] d, w; logic e; int l;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            doReq(1'b1, 4*i, 2, 1'b0, w, d, e, l);
            modelStore(4*i, 2, w);
        end
    endtask

    task automatic test_word_store_load;
        logic [31:0] d; logic e; int l;
        doReq(1'b1, 'h10, 2, 1'b0, 32'hDEADBEEF, d, e, l);
        modelStore('h10, 2, 32'hDEADBEEF);
        checks++; if (e !== 1'b0) $display("[TB] FAIL sw_err: got %b want 0", e); else passed++;
        checks++; if (d !== 32'h0) $display("[TB] FAIL sw_rdata: got %h want 0", d); else passed++;
        doReq(1'b0, 'h10, 2, 1'b0, 32'h0, d, e, l);
        checks++; if (d !== 32'hDEADBEEF) $display("[TB] FAIL lw_rdata: got %h want deadbeef", d); else passed++;
        checks++; if (l !== LAT) $display("[TB] FAIL lw_latency: got %0d want %0d", l, LAT); else passed++;
    endtask

    task automatic test_subword;
        logic [31:0] d; logic e; int l;
        int          addrs [5] = '{'h10, 'h12, 'h12, 'h12, 'h10};
        int          sizes [5] = '{2, 0, 0, 1, 1};
        logic        unss  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exps  [5] = '{32'h5AADBEEF, 32'hFFFFFFAD, 32'h000000AD, 32'h00005AAD, 32'hFFFFBEEF};
        doReq(1'b1, 'h13, 0, 1'b0, 32'hFFFFFF5A, d, e, l);
        modelStore('h13, 0, 32'h5A);
        checks++; if (e !== 1'b0) $display("[TB] FAIL sb_err: got %b want 0", e); else passed++;
        for (int i = 0; i < 5; i++) begin
            doReq(1'b0, addrs[i], sizes[i], unss[i], 32'h0, d, e, l);
            checks++;
            if (d !== exps[i] || e !== 1'b0)
                $display("[TB] FAIL subword_load%0d: got %h err %b want %h err 0", i, d, e, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_misalign;
        logic [31:0] d; logic e; int l;
        doReq(1'b0, 'h11, 2, 1'b0, 32'h0, d, e, l);
        checks++; if (e !== 1'b1 || d !== 32'h0) $display("[TB] FAIL mis_lw: got %h err %b want 0 err 1", d, e); else passed++;
        doReq(1'b1, 'h13, 1, 1'b0, 32'h1234, d, e, l);
        checks++; if (e !== 1'b1 || d !== 32'h0) $display("[TB] FAIL mis_sh: got %h err %b want 0 err 1", d, e); else passed++;
        doReq(1'b0, 'h10, 2, 1'b0, 32'h0, d, e, l);
        checks++; if (d !== 32'h5AADBEEF) $display("[TB] FAIL mis_after_lw: got %h want 5aadbeef", d); else passed++;
    endtask

    task automatic test_backpressure;
        logic [31:0] expQ [$];
        logic [31:0] want;
        int waitCnt, cyc, got, lastCyc, nextReq;
        want = expLoad('h10, 2, 1'b0);
        @(negedge clk);
        reqValid = 1'b1; reqWe = 1'b0; reqAddr = 15'h10; reqSize = 2'd2; reqUns = 1'b0;
        rspReady = 1'b0;
        @(posedge clk);
        #1 reqValid = 1'b0;
        waitCnt = 0;
        do begin @(negedge clk); waitCnt++; end while (!rspValid && waitCnt < 20);
        for (int c = 0; c < 4; c++) begin
            checks++; if (rspValid !== 1'b1) $display("[TB] FAIL bp_valid%0d: got %b want 1", c, rspValid); else passed++;
            checks++; if (rspRdata !== want) $display("[TB] FAIL bp_rdata%0d: got %h want %h", c, rspRdata, want); else passed++;
            checks++; if (rspErr !== 1'b0) $display("[TB] FAIL bp_err%0d: got %b want 0", c, rspErr); else passed++;
            checks++; if (reqReady !== 1'b0) $display("[TB] FAIL bp_ready%0d: got %b want 0", c, reqReady); else passed++;
            if (c < 3) @(negedge clk);
        end
        expQ.push_back(want);
        rspReady = 1'b1;
        cyc = 0; got = 0; lastCyc = 0; nextReq = 0;
        while (got < 5 && cyc < 40) begin
            if (rspValid) begin
                checks++;
                if (expQ.size() == 0) $display("[TB] FAIL bp_order: unexpected response %h", rspRdata);
                else begin
                    want = expQ.pop_front();
                    if (rspRdata !== want) $display("[TB] FAIL bp_order%0d: got %h want %h", got, rspRdata, want);
                    else passed++;
                end
                if (got >= 2) begin
                    checks++;
                    if (cyc - lastCyc !== LAT) $display("[TB] FAIL bp_rate%0d: gap %0d want %0d", got, cyc - lastCyc, LAT);
                    else passed++;
                end
                lastCyc = cyc;
                got++;
            end
            if (nextReq < 4) begin
                reqValid = 1'b1; reqWe = 1'b0; reqAddr = 15'(4*nextReq); reqSize = 2'd2;
                #1;
                if (reqReady) begin
                    expQ.push_back(expLoad(4*nextReq, 2, 1'b0));
                    nextReq++;
                end
            end else reqValid = 1'b0;
            @(negedge clk); cyc++;
        end
        reqValid = 1'b0;
        checks++; if (got !== 5) $display("[TB] FAIL bp_count: got %0d responses want 5", got); else passed++;
    endtask

    task automatic test_random;
        logic [31:0] d, w, wantD; logic e, we, uns, wantE; int l, addr, size;
        for (int i = 0; i < 60; i++) begin
            addr = int'($urandom_range(0, 60));
            size = int'($urandom_range(0, 3));
            we = 1'($urandom); uns = 1'($urandom); w = $urandom;
            wantE = expErr(addr, size);
            wantD = (we || wantE) ? 32'h0 : expLoad(addr, size, uns);
            doReq(we, addr, size, uns, w, d, e, l);
            if (we && !wantE) modelStore(addr, size, w);
            checks++; if (e !== wantE) $display("[TB] FAIL rnd_err%0d: got %b want %b", i, e, wantE); else passed++;
            checks++; if (d !== wantD) $display("[TB] FAIL rnd_rdata%0d: got %h want %h", i, d, wantD); else passed++;
            checks++; if (l !== LAT) $display("[TB] FAIL rnd_lat%0d: got %0d want %0d", i, l, LAT); else passed++;
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d, w; logic e; int l, waitCnt;
        w = $urandom;
        @(negedge clk);
        reqValid = 1'b1; reqWe = 1'b1; reqAddr = 15'h20; reqSize = 2'd2; reqWdata = w;
        rspReady = 1'b0;
        @(posedge clk);
        #1 reqValid = 1'b0;
        modelStore('h20, 2, w);
        waitCnt = 0;
        do begin @(negedge clk); waitCnt++; end while (!rspValid && waitCnt < 20);
        checks++; if (rspValid !== 1'b1) $display("[TB] FAIL rm_pending: got %b want 1", rspValid); else passed++;
        resetN = 1'b0;
        #1;
        checks++; if (rspValid !== 1'b0) $display("[TB] FAIL rm_valid_drop: got %b want 0", rspValid); else passed++;
        checks++; if (reqReady !== 1'b1) $display("[TB] FAIL rm_ready: got %b want 1", reqReady); else passed++;
        @(negedge clk);
        resetN = 1'b1; rspReady = 1'b1;
        doReq(1'b0, 'h20, 2, 1'b0, 32'h0, d, e, l);
        checks++; if (d !== w || e !== 1'b0) $display("[TB] FAIL rm_reload: got %h err %b want %h err 0", d, e, w); else passed++;
    endtask

    initial begin
        resetN = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqSize = '0;
        reqUns = 1'b0; reqWdata = '0; rspReady = 1'b1;
        test_reset();
        preload();
        test_word_store_load();
        test_subword();
        test_misalign();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
